// File: rtl/rv32_decode_exec_unit.sv
// ---------------------------------------------------------------------------
// rv32_decode_exec_unit
//   Single-cycle RV32I decode plus execute slice. Field extraction, immediate
//   generation and control strobes are combinational. The ALU result and the
//   branch/jump decision are registered, so they appear one clock later.
//
// Ports
//   clk           in   1   rising-edge clock
//   rst           in   1   asynchronous active-low reset (clears registers)
//   instr         in  32   RV32I instruction word
//   pc            in  32   address of instr
//   rs1_data      in  32   register-file read data for rs1
//   rs2_data      in  32   register-file read data for rs2
//   rs1/rs2/rd    out  5   instr[19:15] / instr[24:20] / instr[11:7]
//   imm           out 32   sign-extended immediate for the decoded format
//   lw_en, sw_en, wr_en, sub_en, offset_en, mux_sel
//                 out  1   control strobes
//   alu_out       out 32   registered ALU / address / link result
//   branch_taken  out  1   registered branch or jump decision
// ---------------------------------------------------------------------------
module rv32_decode_exec_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [31:0] imm,
  output logic        lw_en,
  output logic        sw_en,
  output logic        wr_en,
  output logic        sub_en,
  output logic        offset_en,
  output logic        mux_sel,
  output logic [31:0] alu_out,
  output logic        branch_taken
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  logic [6:0]  opcode_s;
  logic [2:0]  funct3_s;
  logic [6:0]  funct7_s;
  logic        wr_raw_s;
  logic [31:0] op_b_s;
  logic [31:0] alu_d;
  logic        branch_d;
  logic [31:0] alu_q;
  logic        branch_q;

  assign opcode_s = instr[6:0];
  assign funct3_s = instr[14:12];
  assign funct7_s = instr[31:25];

  assign rs1 = instr[19:15];
  assign rs2 = instr[24:20];
  assign rd  = instr[11:7];

  // Integer ALU shared by register-register and register-immediate forms.
  // The arithmetic shift is kept in its own branch so the signed operand is
  // not turned unsigned by a mixed-sign conditional expression.
  function automatic logic [31:0] alu_op(
    input logic [2:0]  f3,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic        sub,
    input logic        arith
  );
    logic [4:0] shamt;
    shamt = b[4:0];
    case (f3)
      3'b000: begin
        if (sub) alu_op = a - b;
        else     alu_op = a + b;
      end
      3'b001: alu_op = a << shamt;
      3'b010: alu_op = {31'd0, ($signed(a) < $signed(b))};
      3'b011: alu_op = {31'd0, (a < b)};
      3'b100: alu_op = a ^ b;
      3'b101: begin
        if (arith) alu_op = $unsigned($signed(a) >>> shamt);
        else       alu_op = a >> shamt;
      end
      3'b110: alu_op = a | b;
      default: alu_op = a & b;
    endcase
  endfunction

  // Immediate generation, selected purely by opcode.
  always_comb begin
    imm = 32'h0000_0000;
    case (opcode_s)
      OP_I, OP_LOAD, OP_JALR: imm = {{20{instr[31]}}, instr[31:20]};
      OP_STORE:               imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      OP_BRANCH:              imm = {{19{instr[31]}}, instr[31], instr[7],
                                     instr[30:25], instr[11:8], 1'b0};
      OP_LUI, OP_AUIPC:       imm = {instr[31:12], 12'h000};
      OP_JAL:                 imm = {{11{instr[31]}}, instr[31], instr[19:12],
                                     instr[20], instr[30:21], 1'b0};
      default:                imm = 32'h0000_0000;
    endcase
  end

  // Control strobe decode. Unsupported funct3 encodings of load, store,
  // JALR and branch leave every strobe low so they behave as NOPs.
  always_comb begin
    lw_en     = 1'b0;
    sw_en     = 1'b0;
    sub_en    = 1'b0;
    offset_en = 1'b0;
    mux_sel   = 1'b0;
    wr_raw_s  = 1'b0;
    case (opcode_s)
      OP_R: begin
        wr_raw_s = 1'b1;
        sub_en   = (funct3_s == 3'b000) && (funct7_s == 7'b0100000);
      end
      OP_I: begin
        wr_raw_s = 1'b1;
        mux_sel  = 1'b1;
      end
      OP_LOAD: begin
        if (funct3_s == 3'b010) begin
          lw_en    = 1'b1;
          wr_raw_s = 1'b1;
          mux_sel  = 1'b1;
        end else begin
          lw_en    = 1'b0;
        end
      end
      OP_STORE: begin
        if (funct3_s == 3'b010) begin
          sw_en   = 1'b1;
          mux_sel = 1'b1;
        end else begin
          sw_en   = 1'b0;
        end
      end
      OP_LUI, OP_AUIPC: wr_raw_s = 1'b1;
      OP_JAL: begin
        wr_raw_s  = 1'b1;
        offset_en = 1'b1;
      end
      OP_JALR: begin
        if (funct3_s == 3'b000) begin
          wr_raw_s  = 1'b1;
          offset_en = 1'b1;
          mux_sel   = 1'b1;
        end else begin
          offset_en = 1'b0;
        end
      end
      OP_BRANCH: begin
        if ((funct3_s != 3'b010) && (funct3_s != 3'b011)) begin
          offset_en = 1'b1;
        end else begin
          offset_en = 1'b0;
        end
      end
      default: wr_raw_s = 1'b0;
    endcase
    // x0 is hardwired to zero, so a write to it is suppressed.
    wr_en = wr_raw_s && (instr[11:7] != 5'd0);
  end

  assign op_b_s = mux_sel ? imm : rs2_data;

  // Execute: next ALU result and branch decision for the current instruction.
  always_comb begin
    alu_d    = 32'h0000_0000;
    branch_d = 1'b0;
    case (opcode_s)
      OP_R:     alu_d = alu_op(funct3_s, rs1_data, op_b_s, sub_en, funct7_s[5]);
      OP_I:     alu_d = alu_op(funct3_s, rs1_data, op_b_s, 1'b0, funct7_s[5]);
      OP_LOAD, OP_STORE: begin
        if (lw_en || sw_en) alu_d = rs1_data + imm;
        else                alu_d = 32'h0000_0000;
      end
      OP_LUI:   alu_d = imm;
      OP_AUIPC: alu_d = pc + imm;
      OP_JAL: begin
        alu_d    = pc + 32'd4;
        branch_d = 1'b1;
      end
      OP_JALR: begin
        if (offset_en) begin
          alu_d    = pc + 32'd4;
          branch_d = 1'b1;
        end else begin
          alu_d    = 32'h0000_0000;
          branch_d = 1'b0;
        end
      end
      OP_BRANCH: begin
        case (funct3_s)
          3'b000:  branch_d = (rs1_data == rs2_data);
          3'b001:  branch_d = (rs1_data != rs2_data);
          3'b100:  branch_d = ($signed(rs1_data) <  $signed(rs2_data));
          3'b101:  branch_d = ($signed(rs1_data) >= $signed(rs2_data));
          3'b110:  branch_d = (rs1_data <  rs2_data);
          3'b111:  branch_d = (rs1_data >= rs2_data);
          default: branch_d = 1'b0;
        endcase
      end
      default: begin
        alu_d    = 32'h0000_0000;
        branch_d = 1'b0;
      end
    endcase
  end

  // Result registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_q    <= 32'h0000_0000;
      branch_q <= 1'b0;
    end else begin
      alu_q    <= alu_d;
      branch_q <= branch_d;
    end
  end

  assign alu_out      = alu_q;
  assign branch_taken = branch_q;

endmodule

// File: tb/tb_rv32_decode_exec_unit.sv
module tb_rv32_decode_exec_unit;

  logic        clk;
  logic        rst;
  logic [31:0] instr, pc, rs1_data, rs2_data;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] imm;
  logic        lw_en, sw_en, wr_en, sub_en, offset_en, mux_sel;
  logic [31:0] alu_out;
  logic        branch_taken;

  int checks = 0;
  int errors = 0;

  rv32_decode_exec_unit dut (
    .clk(clk), .rst(rst), .instr(instr), .pc(pc),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm),
    .lw_en(lw_en), .sw_en(sw_en), .wr_en(wr_en), .sub_en(sub_en),
    .offset_en(offset_en), .mux_sel(mux_sel),
    .alu_out(alu_out), .branch_taken(branch_taken)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [31:0] JAL16 = {1'b0, 10'b0000001000, 1'b0, 8'h00, 5'd1, 7'b1101111};

  typedef struct {
    string       name;
    logic [31:0] ins, pcv, a, b, imm;
    logic [5:0]  ctrl;   // {lw, sw, wr, sub, offset, mux}
    logic [31:0] alu;
    logic        br;
  } vec_t;

  // Reference ALU straight from the instruction-set rules.
  function automatic logic [31:0] ref_alu(input int f3, input logic [31:0] x, input logic [31:0] y, input bit alt);
    int unsigned sh;
    logic signed [31:0] xs;
    sh = y % 32;
    xs = x;
    case (f3)
      0: return alt ? x - y : x + y;
      1: return x << sh;
      2: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      3: return (x < y) ? 32'd1 : 32'd0;
      4: return x ^ y;
      5: begin
        if (alt) return xs >>> sh;
        return x >> sh;
      end
      6: return x | y;
      default: return x & y;
    endcase
  endfunction

  function automatic bit ref_branch(input int f3, input logic [31:0] x, input logic [31:0] y);
    case (f3)
      0: return x == y;
      1: return x != y;
      4: return $signed(x) < $signed(y);
      5: return $signed(x) >= $signed(y);
      6: return x < y;
      7: return x >= y;
      default: return 1'b0;
    endcase
  endfunction

  task automatic drive(input logic [31:0] i, input logic [31:0] p, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    instr = i; pc = p; rs1_data = a; rs2_data = b;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(JAL16, 32'h40, 32'h0, 32'h0);
    checks++;
    if (alu_out !== 32'h0 || branch_taken !== 1'b0) begin
      errors++; $display("FAIL reset_initial got alu=%h br=%b exp alu=0 br=0", alu_out, branch_taken);
    end
    checks++;
    if (rd !== 5'd1 || imm !== 32'd16 || offset_en !== 1'b1) begin
      errors++; $display("FAIL reset_comb_track got rd=%0d imm=%h off=%b exp rd=1 imm=10 off=1", rd, imm, offset_en);
    end
    @(posedge clk); #1;
    checks++;
    if (alu_out !== 32'h0 || branch_taken !== 1'b0) begin
      errors++; $display("FAIL reset_hold got alu=%h br=%b exp alu=0 br=0", alu_out, branch_taken);
    end
    // release and check the first edge loads normally
    @(negedge clk);
    rst = 1'b1;
    instr = {7'h00, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011}; rs1_data = 32'd5; rs2_data = 32'd7;
    @(posedge clk); #1;
    checks++;
    if (alu_out !== 32'd12) begin
      errors++; $display("FAIL reset_first_load got %h exp %h", alu_out, 32'd12);
    end
  endtask

  task automatic test_directed();
    vec_t v[10];
    v[0] = '{"add",  {7'h00,5'd2,5'd1,3'b000,5'd3,7'b0110011}, 32'h0, 32'd5, 32'd7, 32'h0, 6'b001000, 32'd12, 1'b0};
    v[1] = '{"sub",  {7'h20,5'd2,5'd1,3'b000,5'd3,7'b0110011}, 32'h0, 32'd3, 32'd5, 32'h0, 6'b001100, 32'hFFFFFFFE, 1'b0};
    v[2] = '{"sra",  {7'h20,5'd2,5'd1,3'b101,5'd5,7'b0110011}, 32'h0, 32'h80000000, 32'd4, 32'h0, 6'b001000, 32'hF8000000, 1'b0};
    v[3] = '{"lw",   {12'hFFC,5'd1,3'b010,5'd4,7'b0000011}, 32'h0, 32'h100, 32'h0, 32'hFFFFFFFC, 6'b101001, 32'hFC, 1'b0};
    v[4] = '{"sw",   {7'h00,5'd2,5'd1,3'b010,5'd8,7'b0100011}, 32'h0, 32'h1000, 32'h55, 32'd8, 6'b010001, 32'h1008, 1'b0};
    v[5] = '{"blt",  {7'h00,5'd2,5'd1,3'b100,5'b01000,7'b1100011}, 32'h0, 32'hFFFFFFFF, 32'd1, 32'd8, 6'b000010, 32'h0, 1'b1};
    v[6] = '{"bltu", {7'h00,5'd2,5'd1,3'b110,5'b01000,7'b1100011}, 32'h0, 32'hFFFFFFFF, 32'd1, 32'd8, 6'b000010, 32'h0, 1'b0};
    v[7] = '{"jal",  JAL16, 32'h40, 32'h0, 32'h0, 32'd16, 6'b001010, 32'h44, 1'b1};
    v[8] = '{"addi_f7", {12'h405,5'd1,3'b000,5'd1,7'b0010011}, 32'h0, 32'd10, 32'd99, 32'h405, 6'b001001, 32'h40F, 1'b0};
    v[9] = '{"add_x0", {7'h00,5'd2,5'd1,3'b000,5'd0,7'b0110011}, 32'h0, 32'd5, 32'd7, 32'h0, 6'b000000, 32'd12, 1'b0};
    for (int k = 0; k < 10; k++) begin
      drive(v[k].ins, v[k].pcv, v[k].a, v[k].b);
      checks++;
      if (imm !== v[k].imm) begin
        errors++; $display("FAIL %s imm got %h exp %h", v[k].name, imm, v[k].imm);
      end
      checks++;
      if ({lw_en, sw_en, wr_en, sub_en, offset_en, mux_sel} !== v[k].ctrl) begin
        errors++; $display("FAIL %s ctrl got %b exp %b", v[k].name,
                           {lw_en, sw_en, wr_en, sub_en, offset_en, mux_sel}, v[k].ctrl);
      end
      @(posedge clk); #1;
      checks++;
      if (alu_out !== v[k].alu || branch_taken !== v[k].br) begin
        errors++; $display("FAIL %s result got alu=%h br=%b exp alu=%h br=%b", v[k].name,
                           alu_out, branch_taken, v[k].alu, v[k].br);
      end
    end
  endtask

  task automatic test_nop();
    logic [6:0] ops[5];
    logic [31:0] ins;
    ops[0] = 7'b0000000; ops[1] = 7'b1111111; ops[2] = 7'b0001111;
    ops[3] = 7'b1110011; ops[4] = 7'b0101111;
    for (int k = 0; k < 5; k++) begin
      drive(JAL16, 32'h80, 32'h0, 32'h0);     // leave non-zero results behind
      @(posedge clk);
      ins = {$urandom_range(0, 33554431), ops[k]};
      drive(ins, $urandom, $urandom, $urandom);
      checks++;
      if (imm !== 32'h0 || {lw_en, sw_en, wr_en, sub_en, offset_en, mux_sel} !== 6'b0) begin
        errors++; $display("FAIL nop_comb op=%b got imm=%h ctrl=%b exp 0", ops[k], imm,
                           {lw_en, sw_en, wr_en, sub_en, offset_en, mux_sel});
      end
      @(posedge clk); #1;
      checks++;
      if (alu_out !== 32'h0 || branch_taken !== 1'b0) begin
        errors++; $display("FAIL nop_result op=%b got alu=%h br=%b exp 0", ops[k], alu_out, branch_taken);
      end
    end
  endtask

  task automatic test_async_reset();
    drive(JAL16, 32'h40, 32'h0, 32'h0);
    @(posedge clk); #1;
    checks++;
    if (alu_out !== 32'h44 || branch_taken !== 1'b1) begin
      errors++; $display("FAIL async_pre got alu=%h br=%b exp alu=44 br=1", alu_out, branch_taken);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (alu_out !== 32'h0 || branch_taken !== 1'b0) begin
      errors++; $display("FAIL async_clear got alu=%h br=%b exp alu=0 br=0", alu_out, branch_taken);
    end
    checks++;
    if (imm !== 32'd16 || wr_en !== 1'b1) begin
      errors++; $display("FAIL async_comb got imm=%h wr=%b exp imm=10 wr=1", imm, wr_en);
    end
    @(posedge clk); #1;
    checks++;
    if (alu_out !== 32'h0 || branch_taken !== 1'b0) begin
      errors++; $display("FAIL async_hold got alu=%h br=%b exp 0", alu_out, branch_taken);
    end
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (alu_out !== 32'h44 || branch_taken !== 1'b1) begin
      errors++; $display("FAIL async_release got alu=%h br=%b exp alu=44 br=1", alu_out, branch_taken);
    end
  endtask

  // Back-to-back random stream: one new instruction every cycle.
  task automatic test_random();
    int          kind, f3, s;
    int          br_f3[6];
    bit          alt;
    logic [4:0]  rdf, r1f, r2f;
    logic [31:0] ins, a, b, pcv, e_imm, e_alu, u;
    logic [5:0]  e_ctrl;
    logic        e_br, wr;
    br_f3[0] = 0; br_f3[1] = 1; br_f3[2] = 4; br_f3[3] = 5; br_f3[4] = 6; br_f3[5] = 7;
    for (int n = 0; n < 400; n++) begin
      kind = $urandom_range(0, 8);
      f3   = $urandom_range(0, 7);
      rdf  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      r1f  = 5'($urandom_range(0, 31));
      r2f  = 5'($urandom_range(0, 31));
      a    = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      b    = ($urandom_range(0, 3) == 0) ? a : $urandom;
      pcv  = $urandom & 32'hFFFF_FFFC;
      s    = $urandom_range(0, 4095) - 2048;
      wr   = (rdf != 5'd0);
      e_br = 1'b0;
      e_alu = 32'h0;
      case (kind)
        0: begin
          alt = ($urandom_range(0, 1) == 1);
          ins = {(alt ? 7'h20 : 7'h00), r2f, r1f, 3'(f3), rdf, 7'b0110011};
          e_imm = 32'h0; e_ctrl = {2'b00, wr, (f3 == 0 && alt), 2'b00};
          e_alu = ref_alu(f3, a, b, alt);
        end
        1: begin
          e_imm = s;
          ins = {e_imm[11:0], r1f, 3'(f3), rdf, 7'b0010011};
          e_ctrl = {2'b00, wr, 3'b001};
          e_alu = ref_alu(f3, a, e_imm, (f3 == 5) && e_imm[10]);
        end
        2: begin
          e_imm = s;
          ins = {e_imm[11:0], r1f, 3'b010, rdf, 7'b0000011};
          e_ctrl = {2'b10, wr, 3'b001}; e_alu = a + e_imm;
        end
        3: begin
          e_imm = s;
          ins = {e_imm[11:5], r2f, r1f, 3'b010, e_imm[4:0], 7'b0100011};
          e_ctrl = 6'b010001; e_alu = a + e_imm;
        end
        4, 5: begin
          u = $urandom;
          e_imm = {u[31:12], 12'h000};
          ins = {e_imm[31:12], rdf, (kind == 4) ? 7'b0110111 : 7'b0010111};
          e_ctrl = {2'b00, wr, 3'b000};
          e_alu = (kind == 4) ? e_imm : pcv + e_imm;
        end
        6: begin
          e_imm = 2 * $urandom_range(0, 1048575) - 1048576;
          ins = {e_imm[20], e_imm[10:1], e_imm[11], e_imm[19:12], rdf, 7'b1101111};
          e_ctrl = {2'b00, wr, 3'b010}; e_alu = pcv + 32'd4; e_br = 1'b1;
        end
        7: begin
          e_imm = s;
          ins = {e_imm[11:0], r1f, 3'b000, rdf, 7'b1100111};
          e_ctrl = {2'b00, wr, 3'b011}; e_alu = pcv + 32'd4; e_br = 1'b1;
        end
        default: begin
          f3 = br_f3[$urandom_range(0, 5)];
          e_imm = 2 * $urandom_range(0, 4095) - 4096;
          ins = {e_imm[12], e_imm[10:5], r2f, r1f, 3'(f3), e_imm[4:1], e_imm[11], 7'b1100011};
          e_ctrl = 6'b000010; e_br = ref_branch(f3, a, b);
        end
      endcase
      drive(ins, pcv, a, b);
      checks++;
      if ({rs1, rs2, rd} !== {ins[19:15], ins[24:20], ins[11:7]}) begin
        errors++; $display("FAIL rand_fields n=%0d got %h exp %h", n, {rs1, rs2, rd},
                           {ins[19:15], ins[24:20], ins[11:7]});
      end
      checks++;
      if (imm !== e_imm) begin
        errors++; $display("FAIL rand_imm n=%0d kind=%0d ins=%h got %h exp %h", n, kind, ins, imm, e_imm);
      end
      checks++;
      if ({lw_en, sw_en, wr_en, sub_en, offset_en, mux_sel} !== e_ctrl) begin
        errors++; $display("FAIL rand_ctrl n=%0d kind=%0d ins=%h got %b exp %b", n, kind, ins,
                           {lw_en, sw_en, wr_en, sub_en, offset_en, mux_sel}, e_ctrl);
      end
      @(posedge clk); #1;
      checks++;
      if (alu_out !== e_alu || branch_taken !== e_br) begin
        errors++; $display("FAIL rand_result n=%0d kind=%0d ins=%h a=%h b=%h got alu=%h br=%b exp alu=%h br=%b",
                           n, kind, ins, a, b, alu_out, branch_taken, e_alu, e_br);
      end
    end
  endtask

  initial begin
    rst = 1'b0; instr = 32'h0; pc = 32'h0; rs1_data = 32'h0; rs2_data = 32'h0;
    test_reset();
    test_directed();
    test_nop();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
